// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the gshare branch-predictor front end.
//   BP_INDEX_WIDTH / BP_HIST_WIDTH / BP_DEPTH : default geometry
//   PC_IDX_LSB  : lowest PC bit used for indexing (instructions are 4-byte aligned)
//   ghr_t       : global history register at default geometry
//   bp_entry_t  : one in-flight prediction {PHT index, predicted direction}
//   gshare_hash : PC/history hash, 32 bits wide; callers truncate to their index width
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_INDEX_WIDTH = 8;
    localparam int BP_HIST_WIDTH  = 8;
    localparam int BP_DEPTH       = 4;
    localparam int PC_IDX_LSB     = 2;

    typedef logic [BP_HIST_WIDTH-1:0] ghr_t;

    typedef struct packed {
        logic [BP_INDEX_WIDTH-1:0] index;
        logic                      pred;
    } bp_entry_t;

    // The history is passed already zero-extended to 32 bits, so it lands in the
    // index LSBs. The result is kept at full width so one function serves any
    // INDEX_WIDTH; the caller keeps only the low INDEX_WIDTH bits.
    function automatic logic [31:0] gshare_hash(input logic [31:0] pc,
                                                input logic [31:0] ghr);
        return (pc >> PC_IDX_LSB) ^ ghr;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// -----------------------------------------------------------------------------
// bp_inflight_fifo
// DEPTH-entry synchronous FIFO holding in-flight branch predictions.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   clear_i       : empty the FIFO; wins over a same-cycle push and pop
//   push_data_i   : entry to write
//   head_o        : oldest entry (meaningful only when empty_o = 0)
//   full_o        : count == DEPTH
//   empty_o       : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int  DEPTH   = BP_DEPTH,
    parameter type entry_t = bp_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   clear_i,
    input  entry_t push_data_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    entry_t           mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[head_q];

    // NOTE: state registers use non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity comes solely from the
    // pointers and count, so resetting the data would only cost flops.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/gshare_index_gen.sv
// -----------------------------------------------------------------------------
// gshare_index_gen
// Front end of the gshare direction predictor, upstream of the 2-bit PHT.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   fetch_pc_i        : PC in IF
//   fetch_br_i        : IF holds a conditional branch and advances this cycle
//   pht_pred_i        : PHT prediction for rd_index_o (same-cycle read)
//   rd_index_o        : PHT read index = PC[INDEX_WIDTH+1:2] ^ spec_ghr
//   pred_taken_o      : prediction handed to next-PC logic
//   stall_o           : in-flight FIFO full, IF must hold its branch
//   resolve_valid_i   : conditional branch resolved in EX
//   resolve_taken_i   : its actual direction
//   flush_i           : non-branch redirect, kills all in-flight predictions
//   update_en_o       : PHT update enable
//   update_index_o    : PHT update index (the recorded read index)
//   br_taken_o        : PHT training direction
//   dir_mispredict_o  : resolved direction differs from the recorded prediction
// Two histories are kept: spec_ghr is shifted at fetch with the predicted
// direction, arch_ghr at resolve with the actual one. Any redirect copies the
// (post-resolve) architectural history into the speculative one.
// -----------------------------------------------------------------------------
module gshare_index_gen
    import bp_pkg::*;
#(
    parameter int INDEX_WIDTH = BP_INDEX_WIDTH,
    parameter int HIST_WIDTH  = BP_HIST_WIDTH,
    parameter int DEPTH       = BP_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            fetch_pc_i,
    input  logic                   fetch_br_i,
    input  logic                   pht_pred_i,
    output logic [INDEX_WIDTH-1:0] rd_index_o,
    output logic                   pred_taken_o,
    output logic                   stall_o,
    input  logic                   resolve_valid_i,
    input  logic                   resolve_taken_i,
    input  logic                   flush_i,
    output logic                   update_en_o,
    output logic [INDEX_WIDTH-1:0] update_index_o,
    output logic                   br_taken_o,
    output logic                   dir_mispredict_o
);

    typedef logic [HIST_WIDTH-1:0] hist_t;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic                   pred;
    } entry_t;

    hist_t  spec_ghr_q;
    hist_t  spec_ghr_d;
    hist_t  arch_ghr_q;
    hist_t  arch_ghr_d;

    entry_t head;
    entry_t push_entry;
    logic   fifo_full;
    logic   fifo_empty;

    logic   resolve_ok;
    logic   mispredict;
    logic   do_push;
    logic   do_clear;

    // ---------------------------------------------------------------- fetch side
    assign rd_index_o   = INDEX_WIDTH'(gshare_hash(fetch_pc_i, 32'(spec_ghr_q)));
    assign pred_taken_o = fetch_br_i & pht_pred_i;
    assign stall_o      = fifo_full;

    // A mispredict or flush in the same cycle means the fetched branch is on
    // the wrong path, so it is never recorded.
    assign do_push = fetch_br_i & ~fifo_full & ~mispredict & ~flush_i;

    assign push_entry.index = rd_index_o;
    assign push_entry.pred  = pht_pred_i;

    // -------------------------------------------------------------- resolve side
    // A resolve against an empty FIFO is a protocol error; it is ignored here
    // and flagged by the assertion below.
    assign resolve_ok       = resolve_valid_i & ~fifo_empty;
    assign mispredict       = resolve_ok & (resolve_taken_i ^ head.pred);
    assign update_en_o      = resolve_ok;
    assign update_index_o   = resolve_ok ? head.index : '0;
    assign br_taken_o       = resolve_ok & resolve_taken_i;
    assign dir_mispredict_o = mispredict;

    assign do_clear = mispredict | flush_i;

    // ----------------------------------------------------------------- histories
    // NOTE: every always_comb target gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        arch_ghr_d = arch_ghr_q;
        spec_ghr_d = spec_ghr_q;

        if (resolve_ok) begin
            arch_ghr_d = {arch_ghr_q[HIST_WIDTH-2:0], resolve_taken_i};
        end

        // Repair uses the already-updated architectural history, so a resolve
        // coincident with a flush is folded in before the copy.
        if (do_clear) begin
            spec_ghr_d = arch_ghr_d;
        end else if (do_push) begin
            spec_ghr_d = {spec_ghr_q[HIST_WIDTH-2:0], pht_pred_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_ghr_q <= '0;
            arch_ghr_q <= '0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            arch_ghr_q <= arch_ghr_d;
        end
    end

    // ------------------------------------------------------- in-flight records
    bp_inflight_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (do_push),
        .pop_i       (resolve_ok),
        .clear_i     (do_clear),
        .push_data_i (push_entry),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifndef SYNTHESIS
    resolve_needs_entry: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(resolve_valid_i && fifo_empty)
    ) else $error("resolve_valid_i asserted with no prediction in flight");
`endif

endmodule

// File: tb/tb_gshare_index_gen.sv
// -----------------------------------------------------------------------------
// tb_gshare_index_gen
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a queue-based model of the predictor front end. A few literal
// expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_gshare_index_gen;

    localparam int IW    = 8;
    localparam int HW    = 8;
    localparam int DEPTH = 4;
    localparam int IMASK = (1 << IW) - 1;
    localparam int HMASK = (1 << HW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [31:0]   fetch_pc;
    logic          fetch_br;
    logic          pht_pred;
    logic [IW-1:0] rd_index;
    logic          pred_taken;
    logic          stall;
    logic          resolve_valid;
    logic          resolve_taken;
    logic          flush;
    logic          update_en;
    logic [IW-1:0] update_index;
    logic          br_taken;
    logic          dir_mispredict;

    always #5 clk_i = ~clk_i;

    gshare_index_gen #(
        .INDEX_WIDTH (IW),
        .HIST_WIDTH  (HW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .fetch_pc_i       (fetch_pc),
        .fetch_br_i       (fetch_br),
        .pht_pred_i       (pht_pred),
        .rd_index_o       (rd_index),
        .pred_taken_o     (pred_taken),
        .stall_o          (stall),
        .resolve_valid_i  (resolve_valid),
        .resolve_taken_i  (resolve_taken),
        .flush_i          (flush),
        .update_en_o      (update_en),
        .update_index_o   (update_index),
        .br_taken_o       (br_taken),
        .dir_mispredict_o (dir_mispredict)
    );

    // ------------------------------------------------------------------ model
    typedef struct {
        int index;
        bit pred;
    } m_entry_t;

    m_entry_t q[$];
    int       m_spec;
    int       m_arch;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_index(input logic [31:0] pc);
        return ((pc >> 2) ^ m_spec) & IMASK;
    endfunction

    function automatic bit m_resolve_ok();
        return resolve_valid && (q.size() > 0);
    endfunction

    function automatic bit m_mispredict();
        if (!m_resolve_ok()) return 1'b0;
        return resolve_taken != q[0].pred;
    endfunction

    // Compare every output against what the model says for the current inputs.
    task automatic compare_outputs();
        bit ok;
        ok = m_resolve_ok();
        check("rd_index",     32'(rd_index),       32'(m_index(fetch_pc)));
        check("pred_taken",   32'(pred_taken),     32'(fetch_br & pht_pred));
        check("stall",        32'(stall),          32'(q.size() == DEPTH));
        check("update_en",    32'(update_en),      32'(ok));
        check("update_index", 32'(update_index),   ok ? 32'(q[0].index) : 32'd0);
        check("br_taken",     32'(br_taken),       32'(ok && resolve_taken));
        check("mispredict",   32'(dir_mispredict), 32'(m_mispredict()));
    endtask

    task automatic model_update();
        bit       ok;
        bit       mis;
        bit       push;
        m_entry_t e;
        ok   = m_resolve_ok();
        mis  = m_mispredict();
        push = fetch_br && (q.size() < DEPTH) && !mis && !flush;
        e.index = m_index(fetch_pc);
        e.pred  = pht_pred;
        if (ok) begin
            void'(q.pop_front());
            m_arch = ((m_arch << 1) | int'(resolve_taken)) & HMASK;
        end
        if (mis || flush) begin
            q.delete();
            m_spec = m_arch;
        end else if (push) begin
            q.push_back(e);
            m_spec = ((m_spec << 1) | int'(pht_pred)) & HMASK;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_spec = 0;
        m_arch = 0;
    endtask

    // Called at a negedge: apply inputs, let them settle, compare.
    task automatic set_in(input bit fb, input logic [31:0] pc, input bit pred,
                          input bit rv, input bit rt, input bit fl);
        fetch_br      = fb;
        fetch_pc      = pc;
        pht_pred      = pred;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        #2;
        compare_outputs();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic idle(input logic [31:0] pc);
        set_in(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges, checked while held.
    task automatic do_reset(input logic [31:0] pc);
        fetch_br      = 1'b0;
        pht_pred      = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
        fetch_pc      = pc;
        #1;
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        check("rst_stall",     32'(stall),          32'd0);
        check("rst_update_en", 32'(update_en),      32'd0);
        check("rst_mispred",   32'(dir_mispredict), 32'd0);
        check("rst_rd_index",  32'(rd_index),       (pc >> 2) & IMASK);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        rst_ni        = 1'b0;
        fetch_pc      = '0;
        fetch_br      = 1'b0;
        pht_pred      = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset then idle.
        idle(32'h48);
        check("t1_rd_index",  32'(rd_index),  32'h12);
        check("t1_stall",     32'(stall),     32'd0);
        check("t1_update_en", 32'(update_en), 32'd0);
        tick();

        // Two pushes from PC 0x48.
        set_in(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_idx0", 32'(rd_index), 32'h12);
        check("t2_pred", 32'(pred_taken), 32'd1);
        tick();
        set_in(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_idx1", 32'(rd_index), 32'h13);
        tick();
        idle(32'h0);
        check("t2_spec", 32'(rd_index), 32'h02);

        // Correct resolves of both.
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_uidx0", 32'(update_index),   32'h12);
        check("t3_btk0",  32'(br_taken),       32'd1);
        check("t3_mis0",  32'(dir_mispredict), 32'd0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_uidx1", 32'(update_index),   32'h13);
        check("t3_btk1",  32'(br_taken),       32'd0);
        check("t3_mis1",  32'(dir_mispredict), 32'd0);
        tick();

        // Three entries queued (head predicted 0), then a taken resolve.
        set_in(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_idx0", 32'(rd_index), 32'h02);
        tick();
        set_in(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_mis",    32'(dir_mispredict), 32'd1);
        check("t4_upd_en", 32'(update_en),      32'd1);
        check("t4_uidx",   32'(update_index),   32'h02);
        tick();
        idle(32'h0);
        check("t4_spec", 32'(rd_index), 32'h05);

        // Fill to DEPTH; the same-cycle push above must not have landed.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("t5_not_full", 32'(stall), 32'd0);
            tick();
        end
        set_in(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_full", 32'(stall), 32'd1);
        tick();
        idle(32'h0);
        check("t5_spec_held", 32'(rd_index), 32'h5F);
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_full_at_pop", 32'(stall), 32'd1);
        tick();
        idle(32'h0);
        check("t5_stall_drop", 32'(stall), 32'd0);

        // Flush with a same-cycle resolve from arch_ghr = 0.
        do_reset(32'h48);
        set_in(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t6_upd_en", 32'(update_en),    32'd1);
        check("t6_uidx",   32'(update_index), 32'h12);
        check("t6_btk",    32'(br_taken),     32'd1);
        tick();
        idle(32'h0);
        check("t6_spec", 32'(rd_index), 32'h01);
        tick();

        // Randomized traffic with one asynchronous reset part-way through.
        for (int i = 0; i < 3000; i++) begin
            bit rv;
            if (i == 1500) begin
                do_reset($urandom);
            end
            rv = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            set_in(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   rv, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
